scr1_mem_arb2: RTL

Two-port memory arbiter that shares one core-style memory interface between two requesters: port 0 (instruction fetch) and port 1 (data load/store). It sits between the core's IMEM/DMEM interfaces and the single memory AXI bridge. It arbitrates requests round-robin and holds a grant stable until it is acknowledged. Because the bridge completes requests in order, a tag FIFO of requester IDs routes each response back to the port that issued it.

---
 rtl/scr1_mem_arb2_pkg.sv | 22 ++
 rtl/scr1_arb_tag_fifo.sv | 51 +++++
 rtl/scr1_mem_arb2.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/scr1_mem_arb2_pkg.sv
// Memory-interface types shared by the IMEM/DMEM arbiter and its tag FIFO.
package scr1_mem_arb2_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10,
        SCR1_MEM_WIDTH_ERROR = 2'b11
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

endpackage : scr1_mem_arb2_pkg

// File: rtl/scr1_arb_tag_fifo.sv
// In-order FIFO of 1-bit requester IDs; dout is meaningful only while not empty.
module scr1_arb_tag_fifo #(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  logic pop_i,
    input  logic din_i,
    output logic dout_o,
    output logic full_o,
    output logic empty_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0] mem_q;
    logic [PW-1:0]    wptr_q;
    logic [PW-1:0]    rptr_q;
    logic [CW-1:0]    cnt_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign dout_o  = mem_q[rptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push_ok) wptr_q <= wptr_q + PW'(1);
            if (pop_ok)  rptr_q <= rptr_q + PW'(1);
            case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + CW'(1);
                2'b01:   cnt_q <= cnt_q - CW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= din_i;
    end

endmodule : scr1_arb_tag_fifo

// File: rtl/scr1_mem_arb2.sv
// Round-robin arbiter sharing one memory port between fetch (p0) and load/store (p1);
// responses are returned in order and routed by a tag FIFO of requester IDs.
module scr1_mem_arb2
    import scr1_mem_arb2_pkg::*;
#(
    parameter int unsigned SCR1_ADDR_WIDTH = 32,
    parameter int unsigned SCR1_ARB_OUTST  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       p0_req_i,
    output logic                       p0_req_ack_o,
    input  type_scr1_mem_cmd_e         p0_cmd_i,
    input  type_scr1_mem_width_e       p0_width_i,
    input  logic [SCR1_ADDR_WIDTH-1:0] p0_addr_i,
    input  logic [31:0]                p0_wdata_i,
    output logic [31:0]                p0_rdata_o,
    output type_scr1_mem_resp_e        p0_resp_o,

    input  logic                       p1_req_i,
    output logic                       p1_req_ack_o,
    input  type_scr1_mem_cmd_e         p1_cmd_i,
    input  type_scr1_mem_width_e       p1_width_i,
    input  logic [SCR1_ADDR_WIDTH-1:0] p1_addr_i,
    input  logic [31:0]                p1_wdata_i,
    output logic [31:0]                p1_rdata_o,
    output type_scr1_mem_resp_e        p1_resp_o,

    output logic                       mem_req_o,
    input  logic                       mem_req_ack_i,
    output type_scr1_mem_cmd_e         mem_cmd_o,
    output type_scr1_mem_width_e       mem_width_o,
    output logic [SCR1_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]                mem_wdata_o,
    input  logic [31:0]                mem_rdata_i,
    input  type_scr1_mem_resp_e        mem_resp_i,
    input  logic                       mem_idle_i,
    output logic                       arb_idle_o
);
    logic [1:0] req;
    logic       win_vld;
    logic       win_id;
    logic       accept;
    logic       resp_vld;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_dout;

    logic       last_grant_q, last_grant_d;
    logic       lock_vld_q,   lock_vld_d;
    logic       lock_id_q,    lock_id_d;

    assign req = {p1_req_i, p0_req_i};

    // A lock only applies while the locked port still requests; otherwise fall back to round-robin.
    always_comb begin
        win_vld = |req;
        win_id  = 1'b0;
        if (lock_vld_q && req[lock_id_q]) begin
            win_id = lock_id_q;
        end else if (&req) begin
            win_id = ~last_grant_q;
        end else begin
            win_id = req[1];
        end
    end

    assign mem_req_o    = win_vld & ~fifo_full;
    assign accept       = mem_req_o & mem_req_ack_i;
    assign p0_req_ack_o = mem_req_ack_i & win_vld & (win_id == 1'b0) & ~fifo_full;
    assign p1_req_ack_o = mem_req_ack_i & win_vld & (win_id == 1'b1) & ~fifo_full;

    always_comb begin
        mem_cmd_o   = SCR1_MEM_CMD_RD;
        mem_width_o = SCR1_MEM_WIDTH_BYTE;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (win_vld) begin
            if (win_id) begin
                mem_cmd_o   = p1_cmd_i;
                mem_width_o = p1_width_i;
                mem_addr_o  = p1_addr_i;
                mem_wdata_o = p1_wdata_i;
            end else begin
                mem_cmd_o   = p0_cmd_i;
                mem_width_o = p0_width_i;
                mem_addr_o  = p0_addr_i;
                mem_wdata_o = p0_wdata_i;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        lock_vld_d   = mem_req_o & ~mem_req_ack_i;
        lock_id_d    = lock_id_q;
        if (accept)     last_grant_d = win_id;
        if (lock_vld_d) lock_id_d    = win_id;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            lock_vld_q   <= 1'b0;
            lock_id_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            lock_vld_q   <= lock_vld_d;
            lock_id_q    <= lock_id_d;
        end
    end

    scr1_arb_tag_fifo #(
        .DEPTH (SCR1_ARB_OUTST)
    ) i_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (accept),
        .pop_i   (pop),
        .din_i   (win_id),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // A response with no outstanding tag is dropped rather than misrouted.
    assign resp_vld   = (mem_resp_i != SCR1_MEM_RESP_NOTRDY);
    assign pop        = resp_vld & ~fifo_empty;
    assign p0_resp_o  = (pop && !fifo_dout) ? mem_resp_i  : SCR1_MEM_RESP_NOTRDY;
    assign p0_rdata_o = (pop && !fifo_dout) ? mem_rdata_i : 32'h0;
    assign p1_resp_o  = (pop &&  fifo_dout) ? mem_resp_i  : SCR1_MEM_RESP_NOTRDY;
    assign p1_rdata_o = (pop &&  fifo_dout) ? mem_rdata_i : 32'h0;
    assign arb_idle_o = fifo_empty & mem_idle_i;

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(resp_vld && fifo_empty))
                else $warning("scr1_mem_arb2: response received with no outstanding request");
        end
    end

endmodule : scr1_mem_arb2
